// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch-side constants and predictor counter type.
package riscv_pkg;

  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t SNT = 2'b00;
  localparam bht_ctr_t WNT = 2'b01;
  localparam bht_ctr_t ST  = 2'b11;

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters.
// Combinational read port, synchronous update port.
module bht_2bit
  import riscv_pkg::*;
#(
  parameter int unsigned Entries = 16,
  parameter int unsigned IdxW    = $clog2(Entries)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IdxW-1:0] rd_idx_i,
  output bht_ctr_t        rd_ctr_o,
  input  logic            upd_valid_i,
  input  logic [IdxW-1:0] upd_idx_i,
  input  logic            upd_taken_i
);

  bht_ctr_t ctr_q [Entries];
  bht_ctr_t ctr_d [Entries];

  // Read returns the registered value, so a same-cycle update is seen next cycle.
  assign rd_ctr_o = ctr_q[rd_idx_i];

  // Saturating increment/decrement of the addressed counter.
  always_comb begin
    ctr_d = ctr_q;
    if (upd_valid_i) begin
      if (upd_taken_i) begin
        if (ctr_q[upd_idx_i] != ST) ctr_d[upd_idx_i] = ctr_q[upd_idx_i] + 2'b01;
      end else begin
        if (ctr_q[upd_idx_i] != SNT) ctr_d[upd_idx_i] = ctr_q[upd_idx_i] - 2'b01;
      end
    end
  end

  // Counter array state; reset to weakly not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Entries; i++) ctr_q[i] <= WNT;
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/if_stage_bp.sv
// Instruction fetch stage: PC register, predecode-based branch/JAL prediction,
// and the IF/ID pipeline register feeding the decoder.
module if_stage_bp
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     BHT_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [31:0]     id_instr_o,
  output logic            id_pred_taken_o
);

  localparam int unsigned IdxW = $clog2(BHT_ENTRIES);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [31:0]     id_instr_q, id_instr_d;
  logic            id_pred_q, id_pred_d;

  bht_ctr_t        rd_ctr;
  logic [6:0]      opcode;
  logic [20:0]     j_imm;
  logic [12:0]     b_imm;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic [XLEN-1:0] pc_plus4;
  logic            unused_bits;

  bht_2bit #(
    .Entries(BHT_ENTRIES),
    .IdxW   (IdxW)
  ) u_bht (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (pc_q[IdxW+1:2]),
    .rd_ctr_o   (rd_ctr),
    .upd_valid_i(upd_valid_i),
    .upd_idx_i  (upd_pc_i[IdxW+1:2]),
    .upd_taken_i(upd_taken_i)
  );

  // Only index bits of the update PC and the word part of redirect PC matter.
  assign unused_bits = ^{redirect_pc_i[1:0], upd_pc_i[XLEN-1:IdxW+2], upd_pc_i[1:0]};

  assign imem_addr_o = pc_q;
  assign opcode      = imem_rdata_i[6:0];
  assign j_imm       = {imem_rdata_i[31], imem_rdata_i[19:12], imem_rdata_i[20],
                        imem_rdata_i[30:21], 1'b0};
  assign b_imm       = {imem_rdata_i[31], imem_rdata_i[7], imem_rdata_i[30:25],
                        imem_rdata_i[11:8], 1'b0};
  assign pc_plus4    = pc_q + XLEN'(4);

  // Predecode: JAL always taken, conditional branch follows counter MSB.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = pc_plus4;
    if (opcode == OPC_JAL) begin
      pred_taken  = 1'b1;
      pred_target = pc_q + {{(XLEN-21){j_imm[20]}}, j_imm};
    end else if (opcode == OPC_BRANCH) begin
      pred_taken  = rd_ctr[1];
      pred_target = pc_q + {{(XLEN-13){b_imm[12]}}, b_imm};
    end
  end

  // Next PC and IF/ID contents; redirect from EX beats a stall from ID.
  always_comb begin
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_pred_d  = id_pred_q;
    if (redirect_i) begin
      pc_d       = {redirect_pc_i[XLEN-1:2], 2'b00};
      id_valid_d = 1'b0;
      id_pc_d    = '0;
      id_instr_d = NOP_INSTR;
      id_pred_d  = 1'b0;
    end else if (!stall_i) begin
      pc_d       = pred_taken ? pred_target : pc_plus4;
      id_valid_d = 1'b1;
      id_pc_d    = pc_q;
      id_instr_d = imem_rdata_i;
      id_pred_d  = pred_taken;
    end
  end

  // PC and IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= NOP_INSTR;
      id_pred_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_pred_q  <= id_pred_d;
    end
  end

  assign id_valid_o      = id_valid_q;
  assign id_pc_o         = id_pc_q;
  assign id_instr_o      = id_instr_q;
  assign id_pred_taken_o = id_pred_q;

endmodule

// File: tb/tb_if_stage_bp.sv
// Scoreboard bench for if_stage_bp: driver pushes hand-computed post-edge state,
// monitor pops and compares after every rising edge.
module tb_if_stage_bp;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BEQ  = 32'hFE00_0CE3;  // beq x0,x0,-8
  localparam logic [31:0] JAL  = 32'h0200_006F;  // jal x0,+0x20

  typedef struct packed {
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0, redirect = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0;
  logic [31:0] redirect_pc = '0, upd_pc = '0;
  logic        id_valid, id_pred;
  logic [31:0] id_pc, id_instr;

  logic [31:0] mem [128];
  exp_t        q [$];
  int          checks = 0;
  int          failures = 0;

  if_stage_bp #(
    .XLEN       (32),
    .BHT_ENTRIES(16),
    .RESET_PC   (32'h0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr_o    (imem_addr),
    .imem_rdata_i   (imem_rdata),
    .stall_i        (stall),
    .redirect_i     (redirect),
    .redirect_pc_i  (redirect_pc),
    .upd_valid_i    (upd_valid),
    .upd_pc_i       (upd_pc),
    .upd_taken_i    (upd_taken),
    .id_valid_o     (id_valid),
    .id_pc_o        (id_pc),
    .id_instr_o     (id_instr),
    .id_pred_taken_o(id_pred)
  );

  always #5 clk = ~clk;

  always_comb imem_rdata = (imem_addr[31:9] == '0) ? mem[imem_addr[8:2]] : NOP;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input exp_t e);
    chk({tag, ".addr"},  imem_addr, e.addr);
    chk({tag, ".valid"}, {31'b0, id_valid}, {31'b0, e.v});
    chk({tag, ".pc"},    id_pc, e.pc);
    chk({tag, ".instr"}, id_instr, e.instr);
    chk({tag, ".pred"},  {31'b0, id_pred}, {31'b0, e.pred});
  endtask

  // Apply inputs for the coming edge, record expected state after it.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] e_addr, input logic e_v, input logic [31:0] e_pc,
                      input logic [31:0] e_instr, input logic e_pred);
    exp_t e;
    stall = st; redirect = rd; redirect_pc = rpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut;
    e = '{addr: e_addr, v: e_v, pc: e_pc, instr: e_instr, pred: e_pred};
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare DUT state against the oldest expectation after each edge.
  initial begin
    int n = 0;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        n++;
        chk_state($sformatf("step%0d", n), e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t rst_e;
    rst_e = '{addr: 32'h0, v: 1'b0, pc: 32'h0, instr: NOP, pred: 1'b0};
    for (int i = 0; i < 128; i++) mem[i] = NOP;
    mem[4] = BEQ;  // 0x10
    repeat (2) @(negedge clk);
    chk_state("reset", rst_e);
    rst_n = 1'b1;

    // straight-line fetch
    step(0,0,0, 0,0,0, 32'h04, 1, 32'h00, NOP, 0);
    step(0,0,0, 0,0,0, 32'h08, 1, 32'h04, NOP, 0);
    step(0,0,0, 0,0,0, 32'h0C, 1, 32'h08, NOP, 0);
    step(0,0,0, 0,0,0, 32'h10, 1, 32'h0C, NOP, 0);
    mem[2] = JAL;  // 0x08, PC already past it
    // BEQ with counter 01 -> not taken
    step(0,0,0, 0,0,0, 32'h14, 1, 32'h10, BEQ, 0);
    // two taken updates -> 11
    step(0,0,0, 1,32'h10,1, 32'h18, 1, 32'h14, NOP, 0);
    step(0,0,0, 1,32'h10,1, 32'h1C, 1, 32'h18, NOP, 0);
    step(0,1,32'h10, 0,0,0, 32'h10, 0, 32'h00, NOP, 0);
    step(0,0,0, 0,0,0, 32'h08, 1, 32'h10, BEQ, 1);
    // JAL +0x20
    step(0,0,0, 0,0,0, 32'h28, 1, 32'h08, JAL, 1);
    step(0,0,0, 0,0,0, 32'h2C, 1, 32'h28, NOP, 0);
    // saturation down: 11->10
    step(0,1,32'h10, 1,32'h10,0, 32'h10, 0, 32'h00, NOP, 0);
    // predict from 10 (taken) while same-cycle update 10->01
    step(0,0,0, 1,32'h10,0, 32'h08, 1, 32'h10, BEQ, 1);
    step(0,1,32'h10, 0,0,0, 32'h10, 0, 32'h00, NOP, 0);
    // counter 01 -> not taken; update 01->00
    step(0,0,0, 1,32'h10,0, 32'h14, 1, 32'h10, BEQ, 0);
    // 00 stays 00
    step(0,1,32'h10, 1,32'h10,0, 32'h10, 0, 32'h00, NOP, 0);
    step(0,0,0, 1,32'h10,1, 32'h14, 1, 32'h10, BEQ, 0);
    step(0,1,32'h10, 1,32'h10,1, 32'h10, 0, 32'h00, NOP, 0);
    step(0,0,0, 0,0,0, 32'h08, 1, 32'h10, BEQ, 1);
    // three-cycle stall
    step(1,0,0, 0,0,0, 32'h08, 1, 32'h10, BEQ, 1);
    step(1,0,0, 0,0,0, 32'h08, 1, 32'h10, BEQ, 1);
    step(1,0,0, 0,0,0, 32'h08, 1, 32'h10, BEQ, 1);
    step(0,0,0, 0,0,0, 32'h28, 1, 32'h08, JAL, 1);
    step(0,0,0, 0,0,0, 32'h2C, 1, 32'h28, NOP, 0);
    // redirect wins over stall, low bits cleared
    step(1,1,32'h103, 0,0,0, 32'h100, 0, 32'h00, NOP, 0);
    step(0,0,0, 0,0,0, 32'h104, 1, 32'h100, NOP, 0);

    // mid-operation reset restores counters (idx 4 was 10)
    rst_n = 1'b0;
    #1;
    chk_state("midreset", rst_e);
    rst_n = 1'b1;
    step(0,1,32'h10, 0,0,0, 32'h10, 0, 32'h00, NOP, 0);
    step(0,0,0, 0,0,0, 32'h14, 1, 32'h10, BEQ, 0);
    // PC+4 wraps
    step(0,1,32'hFFFF_FFFF, 0,0,0, 32'hFFFF_FFFC, 0, 32'h00, NOP, 0);
    step(0,0,0, 0,0,0, 32'h0000_0000, 1, 32'hFFFF_FFFC, NOP, 0);

    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
